// File: rtl/cordic_ctrl.sv
// cordic_ctrl: sequencing controller for an iterative CORDIC datapath.
// Accepts one (re, im) sample at a time and walks the pre-stage, NB_ITER
// micro-rotations and the post-stage. The result is held until downstream
// takes it. A new sample may be accepted in the same cycle the result leaves.
module cordic_ctrl #(
  parameter int NB_ITER = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pre_load,
  input  logic [1:0] pre_quadrant,
  input  logic       pre_exchanged,
  output logic       iter_en,
  output logic [3:0] iter_idx,
  output logic       post_load,
  output logic [1:0] post_quadrant,
  output logic       post_exchanged,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_POST,
    S_HOLD
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NB_ITER - 1);

  state_t state, state_nxt;
  logic   accept;
  logic   last_iter;

  assign last_iter = (iter_idx == LAST_IDX);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Rotation index and the pre-stage side info the post-stage needs later.
  // The side info is only valid from the pre-stage during PRE, so it is
  // captured there and held until the next transaction's PRE.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_idx       <= '0;
      post_quadrant  <= '0;
      post_exchanged <= 1'b0;
    end else if (state == S_PRE) begin
      iter_idx       <= '0;
      post_quadrant  <= pre_quadrant;
      post_exchanged <= pre_exchanged;
    end else if (state == S_ITER && !last_iter) begin
      iter_idx <= iter_idx + 4'd1;
    end
  end

  // Handshakes, stage strobes and next-state selection.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    iter_en   = 1'b0;
    post_load = 1'b0;

    case (state)
      S_IDLE: in_ready  = 1'b1;
      S_ITER: iter_en   = 1'b1;
      S_POST: post_load = 1'b1;
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase

    // Strobes are gated so nothing fires while reset is held.
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      iter_en   = 1'b0;
      post_load = 1'b0;
    end

    accept   = in_valid & in_ready;
    pre_load = accept;
    busy     = !rst && (state != S_IDLE);

    case (state)
      S_IDLE: if (accept) state_nxt = S_PRE;
      S_PRE:  state_nxt = S_ITER;
      S_ITER: if (last_iter) state_nxt = S_POST;
      S_POST: state_nxt = S_HOLD;
      S_HOLD: if (out_ready) state_nxt = accept ? S_PRE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    if (rst) state_nxt = S_IDLE;
  end

endmodule

// File: tb/tb_cordic_ctrl.sv
// tb_cordic_ctrl: two controllers (NB_ITER=11 and NB_ITER=1) share one
// stimulus stream. A timestamp-based reference model predicts every output
// each cycle and pushes side info into per-instance scoreboards; a monitor
// pops them on each output handshake.
module tb_cordic_ctrl;

  typedef struct packed {
    logic [1:0] q;
    logic       e;
  } side_t;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, pre_exchanged;
  logic [1:0] pre_quadrant;

  logic [1:0]       in_ready, out_valid, pre_load, iter_en, post_load;
  logic [1:0]       post_exchanged, busy;
  logic [1:0][3:0]  iter_idx;
  logic [1:0][1:0]  post_quadrant;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  side_t sbq[2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cordic_ctrl #(.NB_ITER(g == 0 ? 11 : 1)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready[g]),
      .out_valid     (out_valid[g]),
      .out_ready     (out_ready),
      .pre_load      (pre_load[g]),
      .pre_quadrant  (pre_quadrant),
      .pre_exchanged (pre_exchanged),
      .iter_en       (iter_en[g]),
      .iter_idx      (iter_idx[g]),
      .post_load     (post_load[g]),
      .post_quadrant (post_quadrant[g]),
      .post_exchanged(post_exchanged[g]),
      .busy          (busy[g])
    );
  end

  // Reference model: a transaction accepted in cycle t occupies PRE at t+1,
  // rotations t+2..t+nb+1, post load t+nb+2, and waits from t+nb+3 onwards.
  bit         have [2];
  int         t_acc [2];
  int         idx_hold [2];
  logic [1:0] sq [2];
  logic       se [2];

  always @(negedge clk) begin
    int nb, n;
    bit hold, e_rdy, e_pl, e_it, e_pol, e_ov, e_busy;
    logic [3:0]  e_idx;
    logic [12:0] got, want;
    n = cyc;
    for (int k = 0; k < 2; k++) begin
      nb = (k == 0) ? 11 : 1;
      hold   = have[k] && (n >= t_acc[k] + nb + 3);
      e_ov   = !rst && hold;
      e_rdy  = !rst && (!have[k] || (hold && out_ready));
      e_pl   = in_valid && e_rdy;
      e_it   = !rst && have[k] && (n >= t_acc[k] + 2) && (n <= t_acc[k] + nb + 1);
      e_pol  = !rst && have[k] && (n == t_acc[k] + nb + 2);
      e_busy = !rst && have[k];
      if (have[k] && n >= t_acc[k] + 2)
        e_idx = 4'((n - t_acc[k] - 2) < (nb - 1) ? (n - t_acc[k] - 2) : (nb - 1));
      else
        e_idx = 4'(idx_hold[k]);

      if (started) begin
        want = {e_rdy, e_pl, e_it, e_idx, e_pol, e_ov, e_busy, sq[k], se[k]};
        got  = {in_ready[k], pre_load[k], iter_en[k], iter_idx[k], post_load[k],
                out_valid[k], busy[k], post_quadrant[k], post_exchanged[k]};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL ctrl nb=%0d cyc=%0d got=%b want=%b (rdy pl it idx4 pol ov busy q2 e)",
                   nb, n, got, want);
        end
      end

      if (rst) begin
        have[k]     = 0;
        idx_hold[k] = 0;
        sq[k]       = 2'b00;
        se[k]       = 1'b0;
        sbq[k].delete();
      end else begin
        if (have[k] && n == t_acc[k] + 1) begin
          sq[k] = pre_quadrant;
          se[k] = pre_exchanged;
          sbq[k].push_back('{q: pre_quadrant, e: pre_exchanged});
        end
        if (have[k] && n >= t_acc[k] + 2) idx_hold[k] = int'(e_idx);
        if (hold && out_ready) have[k] = 0;
        if (e_pl) begin
          have[k]  = 1;
          t_acc[k] = n;
        end
      end
    end
    if (rst) started = 1;
  end

  // Monitor: every output handshake must match the oldest captured side info.
  always @(negedge clk) begin
    side_t exp_s;
    if (started && !rst) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k] === 1'b1 && out_ready) begin
          n_cmp++;
          if (sbq[k].size() == 0) begin
            n_bad++;
            $display("FAIL result k=%0d cyc=%0d got=unexpected output want=none", k, cyc);
          end else begin
            exp_s = sbq[k].pop_front();
            if ({post_quadrant[k], post_exchanged[k]} !== exp_s) begin
              n_bad++;
              $display("FAIL result k=%0d cyc=%0d got q=%0d e=%0d want q=%0d e=%0d",
                       k, cyc, post_quadrant[k], post_exchanged[k], exp_s.q, exp_s.e);
            end
          end
        end
      end
    end
  end

  task automatic step(input bit v, input bit r, input bit s);
    @(posedge clk);
    #1;
    in_valid      = v;
    out_ready     = r;
    rst           = s;
    pre_quadrant  = 2'($urandom);
    pre_exchanged = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    pre_quadrant = 2'b00; pre_exchanged = 1'b0;
    repeat (3) step(0, 0, 1);
    repeat (2) step(0, 1, 0);

    // single transaction, result taken immediately
    step(1, 1, 0);
    repeat (20) step(0, 1, 0);

    // backpressure in HOLD with a sample waiting upstream
    step(1, 1, 0);
    repeat (18) step(1, 0, 0);
    step(1, 1, 0);
    repeat (20) step(0, 1, 0);

    // back-to-back streaming
    repeat (45) step(1, 1, 0);
    repeat (20) step(0, 1, 0);

    // reset while rotating (iter_idx 5 on the NB_ITER=11 instance)
    step(1, 1, 0);
    repeat (6) step(0, 1, 0);
    step(0, 1, 1);
    repeat (5) step(0, 1, 0);
    step(1, 1, 0);
    repeat (20) step(0, 1, 0);

    // random traffic with occasional reset
    repeat (3000)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);

    repeat (30) step(0, 1, 0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (sbq[k].size() != 0) begin
        n_bad++;
        $display("FAIL drain k=%0d got=%0d pending want=0", k, sbq[k].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_ctrl.md
CORDIC_CTRL -- requirements
Module: cordic_ctrl

Interface
REQ-001 SHALL have parameter NB_ITER, default 11, number of CORDIC micro-rotations per transaction; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream sample (re, im) present.
REQ-005 SHALL have port in_ready  output  1  controller accepts a sample this cycle.
REQ-006 SHALL have port out_valid  output  1  post-stage result (amp, phi) valid.
REQ-007 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-008 SHALL have port pre_load  output  1  pre-stage registers capture re, im.
REQ-009 SHALL have port pre_quadrant  input  2  original_quadrant_id produced by the pre-stage.
REQ-010 SHALL have port pre_exchanged  input  1  signals_exchanged produced by the pre-stage.
REQ-011 SHALL have port iter_en  output  1  iteration stage performs one micro-rotation.
REQ-012 SHALL have port iter_idx  output  4  current micro-rotation index (shift amount / atan table address).
REQ-013 SHALL have port post_load  output  1  post-stage registers capture re, im, phi.
REQ-014 SHALL have port post_quadrant  output  2  registered original_quadrant_id for the post-stage.
REQ-015 SHALL have port post_exchanged  output  1  registered signals_exchanged for the post-stage.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, PRE, ITER, POST, HOLD.
REQ-018 SHALL drive in_ready combinationally: 1 in IDLE; out_ready in HOLD; 0 in PRE, ITER, POST and while rst is high.
REQ-019 SHALL define accept as in_valid & in_ready; pre_load SHALL equal accept, combinationally, in the same cycle.
REQ-020 SHALL ignore in_valid when in_ready is 0; no sample is buffered.
REQ-021 SHALL move to PRE on the edge ending an accept cycle (from IDLE or HOLD).
REQ-022 In PRE, SHALL register pre_quadrant and pre_exchanged into post_quadrant/post_exchanged, load iter_idx with 0, and move to ITER.
REQ-023 In ITER, SHALL assert iter_en for exactly NB_ITER consecutive cycles, with iter_idx = 0, 1, ..., NB_ITER-1 in successive cycles.
REQ-024 SHALL leave ITER for POST after the cycle with iter_idx = NB_ITER-1; iter_idx SHALL hold that value outside ITER until the next PRE.
REQ-025 In POST, SHALL assert post_load for exactly one cycle, then move to HOLD.
REQ-026 In HOLD, SHALL assert out_valid and keep post_quadrant/post_exchanged stable until out_ready is 1.
REQ-027 HOLD with out_ready=1: in_valid=1 -> PRE (back-to-back accept); in_valid=0 -> IDLE; out_valid low the next cycle.
REQ-028 Latency: accept in cycle 0 -> PRE cycle 1, ITER cycles 2..NB_ITER+1, POST cycle NB_ITER+2, out_valid first high in cycle NB_ITER+3.
REQ-029 Sustained throughput with out_ready tied high SHALL be one transaction per NB_ITER+3 cycles.
REQ-030 iter_en, pre_load and post_load SHALL never be high in the same cycle.

Reset
REQ-031 While rst is high, the next state SHALL be IDLE; iter_idx=0, post_quadrant=0, post_exchanged=0 after the edge.
REQ-032 While rst is high, out_valid, iter_en, post_load, pre_load, in_ready and busy SHALL be 0.
REQ-033 rst asserted in any state SHALL abort the transaction; it SHALL never produce out_valid afterwards, and in_ready SHALL be 1 in the first cycle after rst falls.

Verification
REQ-034 Single transaction, NB_ITER=11, out_ready=1: accept at cycle 0 -> iter_idx 0..10 on cycles 2..12, post_load cycle 13, out_valid cycle 14 only.
REQ-035 Side info: pre_quadrant=2'b11, pre_exchanged=1 in PRE cycle, then inputs changed -> post_quadrant=3, post_exchanged=1 held through HOLD.
REQ-036 Backpressure: out_ready=0 for 5 cycles in HOLD, in_valid=1 -> out_valid high 6 cycles, in_ready=0 until out_ready=1, accept on the same cycle.
REQ-037 Back-to-back: in_valid and out_ready constantly 1, NB_ITER=11 -> accepts at cycles 0, 14, 28; out_valid at cycles 14, 28.
REQ-038 Reset in ITER (iter_idx=5) -> next cycle IDLE, iter_en=0, no out_valid; new accept then completes with normal latency.
REQ-039 NB_ITER=1 boundary: accept cycle 0 -> single iter_en cycle 2 with iter_idx=0, out_valid cycle 4.
